// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared state encoding, default sizes and port indices for the data memory arbiter.
package data_mem_arb_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 16;
  localparam int DEF_MAX_BURST = 8;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
endpackage

// File: rtl/data_mem_arbiter_mux.sv
// arb_port_mux: steers we/addr/wdata of the granted port onto the memory bus, zero when nothing is granted.
module arb_port_mux
  import data_mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          i_gnt,
  input  logic          i_sel,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata
);
  always_comb begin
    o_we    = !i_gnt ? 1'b0 : (i_sel == PORT1) ? i_we1 : i_we0;
    o_addr  = !i_gnt ? '0   : (i_sel == PORT1) ? i_addr1 : i_addr0;
    o_wdata = !i_gnt ? '0   : (i_sel == PORT1) ? i_wdata1 : i_wdata0;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin arbiter with locked bursts in front of a single-port memory.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata0,
  output logic [DW-1:0] o_rdata1,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);
  localparam logic LOCKABLE = MAX_BURST > 1;
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  state_t     r_state;
  logic       r_ptr;
  logic [7:0] r_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic       w_idle;
  logic       w_sel;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_gnt;
  logic       w_lock;
  logic       w_req;
  logic [7:0] w_cnt_nxt;
  logic       w_exit;
  always_comb begin
    w_idle    = r_state == IDLE;
    w_sel     = w_idle ? ((i_req0 & i_req1) ? r_ptr : (i_req1 ? PORT1 : PORT0))
                       : ((r_state == OWN1) ? PORT1 : PORT0);
    w_gnt0    = !i_rst & (w_idle ? (i_req0 & (w_sel == PORT0)) : ((r_state == OWN0) & i_req0));
    w_gnt1    = !i_rst & (w_idle ? (i_req1 & (w_sel == PORT1)) : ((r_state == OWN1) & i_req1));
    w_gnt     = w_gnt0 | w_gnt1;
    w_lock    = (w_sel == PORT1) ? i_lock1 : i_lock0;
    w_req     = (w_sel == PORT1) ? i_req1 : i_req0;
    w_cnt_nxt = r_cnt + 8'd1;
    // an owner leaves on an unlocked beat, on the burst-limit beat, or by withdrawing both req and lock
    w_exit    = w_gnt ? (!w_lock | (w_cnt_nxt == BURST_LIMIT)) : (!w_req & !w_lock);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= PORT0;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & !i_we0;
      r_rvalid1 <= w_gnt1 & !i_we1;
      if (w_idle) begin
        if (w_gnt & w_lock & LOCKABLE) begin
          r_state <= (w_sel == PORT1) ? OWN1 : OWN0;
          r_cnt   <= 8'd1;
        end else if (w_gnt) begin
          r_ptr <= ~w_sel;
        end
      end else if (w_exit) begin
        r_state <= IDLE;
        r_ptr   <= ~w_sel;
        r_cnt   <= '0;
      end else if (w_gnt) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end
  arb_port_mux #(.DW(DW), .AW(AW)) u_mux (
    .i_gnt   (w_gnt),
    .i_sel   (w_sel),
    .i_we0   (i_we0),
    .i_we1   (i_we1),
    .i_addr0 (i_addr0),
    .i_addr1 (i_addr1),
    .i_wdata0(i_wdata0),
    .i_wdata1(i_wdata1),
    .o_we    (o_mem_we),
    .o_addr  (o_mem_addr),
    .o_wdata (o_mem_wdata)
  );
  assign o_gnt0    = w_gnt0;
  assign o_gnt1    = w_gnt1;
  assign o_mem_en  = w_gnt;
  assign o_busy    = (r_state == OWN0) | (r_state == OWN1);
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  // memory data arrives the cycle after the strobe, exactly when the registered rvalid is up
  assign o_rdata0  = r_rvalid0 ? i_mem_rdata : '0;
  assign o_rdata1  = r_rvalid1 ? i_mem_rdata : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed table of arbitration vectors plus hand sequences for bursts, read latency and reset.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem [0:255];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic r0, r1, l0, l1;
    logic eg0, eg1, ebusy;
    logic [15:0] emaddr;
  } vec_t;
  vec_t tv [14];

  always #5 clk = ~clk;

  data_mem_arbiter #(.DW(16), .AW(16), .MAX_BURST(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_lock0(lock0), .i_lock1(lock1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_grant(input string nm, input logic g0, input logic g1, input logic b);
    chk({nm, ".gnt0"}, gnt0, g0);
    chk({nm, ".gnt1"}, gnt1, g1);
    chk({nm, ".busy"}, busy, b);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    tv[0]  = '{1,1,0,0, 1,0,0, 16'h0100};
    tv[1]  = '{1,1,0,0, 0,1,0, 16'h0200};
    tv[2]  = '{1,1,0,0, 1,0,0, 16'h0100};
    tv[3]  = '{1,1,0,0, 0,1,0, 16'h0200};
    tv[4]  = '{0,1,0,0, 0,1,0, 16'h0200};
    tv[5]  = '{1,0,0,0, 1,0,0, 16'h0100};
    tv[6]  = '{0,0,0,0, 0,0,0, 16'h0000};
    tv[7]  = '{1,1,0,1, 0,1,0, 16'h0200};
    tv[8]  = '{1,1,0,0, 0,1,1, 16'h0200};
    tv[9]  = '{1,1,1,0, 1,0,0, 16'h0100};
    tv[10] = '{0,1,1,0, 0,0,1, 16'h0000};
    tv[11] = '{0,1,0,0, 0,0,1, 16'h0000};
    tv[12] = '{1,1,0,0, 0,1,0, 16'h0200};
    tv[13] = '{1,0,0,0, 1,0,0, 16'h0100};

    req0 = 1; req1 = 1; we0 = 1;
    #2;
    chk_grant("rst", 0, 0, 0);
    chk("rst.mem_en", mem_en, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.rvalid", {rvalid0, rvalid1}, 0);
    chk("rst.rdata", {rdata0, rdata1}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; we0 = 0;
    addr0 = 16'h0100; addr1 = 16'h0200;

    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      req0 = tv[i].r0; req1 = tv[i].r1; lock0 = tv[i].l0; lock1 = tv[i].l1;
      #1;
      chk_grant($sformatf("vec%0d", i), tv[i].eg0, tv[i].eg1, tv[i].ebusy);
      chk($sformatf("vec%0d.mem_addr", i), mem_addr, tv[i].emaddr);
      chk($sformatf("vec%0d.mem_en", i), mem_en, tv[i].eg0 | tv[i].eg1);
    end

    // write then read-after-write on port 0, then back-to-back reads on port 1
    @(negedge clk);
    req0 = 1; req1 = 0; lock0 = 0; lock1 = 0; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    #1;
    chk("wr.gnt0", gnt0, 1);
    chk("wr.mem_we", mem_we, 1);
    chk("wr.mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr.mem_addr", mem_addr, 16'h0010);
    @(negedge clk);
    we0 = 0;
    #1;
    chk("rd.gnt0", gnt0, 1);
    chk("rd.mem_we", mem_we, 0);
    chk("rd.rvalid0_after_wr", rvalid0, 0);
    @(negedge clk);
    req0 = 0; req1 = 1; we1 = 0; addr1 = 16'h0010;
    #1;
    chk("rd.rvalid0", rvalid0, 1);
    chk("rd.rdata0", rdata0, 16'hBEEF);
    chk("rd.rvalid1_quiet", rvalid1, 0);
    chk("b2b.gnt1a", gnt1, 1);
    @(negedge clk);
    #1;
    chk("rd.rvalid0_once", rvalid0, 0);
    chk("b2b.gnt1b", gnt1, 1);
    chk("b2b.rvalid1a", rvalid1, 1);
    chk("b2b.rdata1a", rdata1, 16'hBEEF);
    @(negedge clk);
    req1 = 0;
    #1;
    chk("b2b.rvalid1b", rvalid1, 1);
    chk("b2b.rdata1b", rdata1, 16'hBEEF);
    @(negedge clk);
    #1;
    chk("b2b.rvalid1_end", rvalid1, 0);

    // move the pointer to port 1, then a full locked burst while port 0 keeps asking
    @(negedge clk);
    req0 = 1; addr0 = 16'h0030;
    #1;
    chk("pre.gnt0", gnt0, 1);
    @(negedge clk);
    req1 = 1; lock1 = 1; addr1 = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk_grant($sformatf("burst%0d", k), 0, 1, k > 0);
    end
    @(negedge clk);
    #1;
    chk_grant("burst_end", 1, 0, 0);

    // port 1 locks, withdraws its request while keeping the lock, then releases
    @(negedge clk);
    #1;
    chk_grant("hold.enter", 0, 1, 0);
    @(negedge clk);
    req1 = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk_grant($sformatf("hold%0d", k), 0, 0, 1);
    end
    @(negedge clk);
    lock1 = 0;
    #1;
    chk_grant("hold.release", 0, 0, 1);
    @(negedge clk);
    #1;
    chk_grant("hold.after", 1, 0, 0);

    // reset in the middle of a locked burst with a read in flight
    @(negedge clk);
    req0 = 0; req1 = 1; lock1 = 1; we1 = 0; addr1 = 16'h0010;
    #1;
    chk_grant("rstmid.enter", 0, 1, 0);
    @(negedge clk);
    #1;
    chk_grant("rstmid.own", 0, 1, 1);
    #2;
    rst = 1;
    #1;
    chk_grant("rstmid.asserted", 0, 0, 0);
    chk("rstmid.mem_en", mem_en, 0);
    @(posedge clk);
    #1;
    chk("rstmid.rvalid1", rvalid1, 0);
    @(negedge clk);
    rst = 0; req0 = 1; req1 = 1; lock1 = 0;
    #1;
    chk_grant("rstmid.rr", 1, 0, 0);
    chk("rstmid.rvalid1_late", rvalid1, 0);
    @(negedge clk);
    req0 = 0; req1 = 0;
    #1;
    chk("rstmid.rvalid1_none", rvalid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
